// File: rtl/prog_tick_divider.sv
// prog_tick_divider
//   NUM_CH independent programmable clock-enable dividers. Each channel
//   produces a single-cycle tick every div cycles and a 50%-duty divided
//   clock with a period of 2*div cycles. Divide ratios are staged through a
//   per-channel pending register. The pending value is adopted only at a
//   period boundary (terminal count, restart or while disabled), so a
//   running channel never produces a short or partial period.
//
// Ports
//   clk          in   system clock, rising edge
//   arst_n       in   asynchronous active-low reset
//   ch_en        in   [NUM_CH]  per-channel run enable
//   sync_restart in   synchronous restart of every channel (one-cycle pulse)
//   cfg_wr       in   config write strobe
//   cfg_ch       in   [CH_W]    target channel of cfg_wr
//   cfg_div      in   [CNT_W]   new divide ratio
//   cfg_ack      out  write accepted, one cycle after cfg_wr
//   cfg_err      out  write rejected, one cycle after cfg_wr
//   tick         out  [NUM_CH]  single-cycle enable, period div cycles
//   div_out      out  [NUM_CH]  divided clock, period 2*div cycles
//
// Config handshake: cfg_wr is a one-cycle strobe with no back-pressure; a
// write can be issued every cycle. Exactly one of cfg_ack / cfg_err pulses
// on the cycle after each strobe, never both. A write is accepted when
// cfg_ch < NUM_CH and cfg_div != 0; a rejected write changes no state.

module prog_tick_divider #(
    parameter int          NUM_CH  = 4,
    parameter int          CNT_W   = 32,
    parameter int unsigned DEF_DIV = 134217728,
    parameter int          CH_W    = 4
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync_restart,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic              cfg_ack,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] div_out
);

    localparam logic [CNT_W-1:0] DEF_DIV_L = CNT_W'(DEF_DIV);
    // One extra bit so NUM_CH itself is representable (e.g. 16 with CH_W=4).
    localparam logic [CH_W:0]    NUM_CH_L  = (CH_W + 1)'(NUM_CH);

    logic cfg_ok;
    logic ack_q;
    logic err_q;

    assign cfg_ok = cfg_wr && ({1'b0, cfg_ch} < NUM_CH_L) && (cfg_div != '0);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ack_q <= cfg_ok;
            err_q <= cfg_wr && !cfg_ok;
        end
    end

    assign cfg_ack = ack_q;
    assign cfg_err = err_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] div_q, div_d;
        logic [CNT_W-1:0] pend_q, pend_d;
        logic             pend_vld_q, pend_vld_d;
        logic             tick_q, tick_d;
        logic             dout_q, dout_d;
        logic             terminal;
        logic             wr_hit;

        assign terminal = (cnt_q == div_q - CNT_W'(1));
        assign wr_hit   = cfg_ok && (cfg_ch == CH_W'(i));

        always_comb begin
            cnt_d      = cnt_q + CNT_W'(1);
            div_d      = div_q;
            pend_d     = pend_q;
            pend_vld_d = pend_vld_q;
            tick_d     = 1'b0;
            dout_d     = dout_q;

            // Restart/disable outrank terminal detection. All three are period
            // boundaries, so each adopts the pending ratio held before the edge.
            if (sync_restart || !ch_en[i]) begin
                cnt_d  = '0;
                dout_d = 1'b0;
                if (pend_vld_q) begin
                    div_d      = pend_q;
                    pend_vld_d = 1'b0;
                end
            end else if (terminal) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                dout_d = !dout_q;
                if (pend_vld_q) begin
                    div_d      = pend_q;
                    pend_vld_d = 1'b0;
                end
            end

            // A write in the same cycle as a boundary lands after the boundary
            // consumed the old pending value, so it governs the following period.
            if (wr_hit) begin
                pend_d     = cfg_div;
                pend_vld_d = 1'b1;
            end
        end

        always_ff @(posedge clk or negedge arst_n) begin
            if (!arst_n) begin
                cnt_q      <= '0;
                div_q      <= DEF_DIV_L;
                pend_q     <= '0;
                pend_vld_q <= 1'b0;
                tick_q     <= 1'b0;
                dout_q     <= 1'b0;
            end else begin
                cnt_q      <= cnt_d;
                div_q      <= div_d;
                pend_q     <= pend_d;
                pend_vld_q <= pend_vld_d;
                tick_q     <= tick_d;
                dout_q     <= dout_d;
            end
        end

        assign tick[i]    = tick_q;
        assign div_out[i] = dout_q;
    end

endmodule

// File: tb/tb_prog_tick_divider.sv
module tb_prog_tick_divider;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 16;
  localparam int DEF_DIV = 8;
  localparam int CH_W    = 4;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              arst_n;
  logic [NUM_CH-1:0] ch_en;
  logic              sync_restart;
  logic              cfg_wr;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic              cfg_ack;
  logic              cfg_err;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] div_out;

  always #5 clk = ~clk;

  prog_tick_divider #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .DEF_DIV(DEF_DIV),
    .CH_W   (CH_W)
  ) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .ch_en       (ch_en),
    .sync_restart(sync_restart),
    .cfg_wr      (cfg_wr),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .cfg_ack     (cfg_ack),
    .cfg_err     (cfg_err),
    .tick        (tick),
    .div_out     (div_out)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int ch, input int dv);
    cfg_wr  = 1'b1;
    cfg_ch  = CH_W'(ch);
    cfg_div = CNT_W'(dv);
    step();
    cfg_wr  = 1'b0;
  endtask

  // Number of edges until tick[ch] is seen high; -1 if the bound expires.
  task automatic find_tick(input int ch, input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick[ch] && n < limit);
    if (!tick[ch]) n = -1;
  endtask

  int n;
  int divs[4] = '{2, 3, 4, 6};
  logic [NUM_CH-1:0] exp_tick;
  logic [NUM_CH-1:0] exp_dout;

  initial begin
    arst_n       = 1'b0;
    ch_en        = '0;
    sync_restart = 1'b0;
    cfg_wr       = 1'b0;
    cfg_ch       = '0;
    cfg_div      = '0;
    repeat (3) step();
    check("rst_tick", tick, 0);
    check("rst_dout", div_out, 0);
    check("rst_ack", cfg_ack, 0);
    check("rst_err", cfg_err, 0);

    // ch0: first period at DEF_DIV, then ratio 5 after the terminal
    arst_n = 1'b1;
    ch_en  = 4'b0001;
    cfg_write(0, 5);
    check("t1_ack", cfg_ack, 1);
    check("t1_err", cfg_err, 0);
    find_tick(0, 20, n);
    check("t1_first_tick", n, 7);
    check("t1_dout_hi", div_out[0], 1);
    find_tick(0, 20, n);
    check("t1_per5_a", n, 5);
    check("t1_dout_lo", div_out[0], 0);
    find_tick(0, 20, n);
    check("t1_per5_b", n, 5);
    check("t1_dout_hi2", div_out[0], 1);

    // ch1: ratio 3, then 7 written mid-period
    cfg_write(1, 3);
    step();                         // disabled channel adopts pending at once
    ch_en = 4'b0011;
    step();
    find_tick(1, 20, n);
    check("t2_per3", n, 2);
    cfg_write(1, 7);
    check("t2_ack", cfg_ack, 1);
    find_tick(1, 20, n);
    check("t2_per3_done", n, 2);
    find_tick(1, 20, n);
    check("t2_per7_a", n, 7);
    find_tick(1, 20, n);
    check("t2_per7_b", n, 7);

    // invalid writes
    cfg_write(2, 0);
    check("t3_err_div0", cfg_err, 1);
    check("t3_ack_div0", cfg_ack, 0);
    cfg_write(9, 4);
    check("t3_err_ch9", cfg_err, 1);
    check("t3_ack_ch9", cfg_ack, 0);
    ch_en = 4'b0111;
    step();
    check("t3_err_clr", cfg_err, 0);
    find_tick(2, 20, n);
    check("t3_ch2_def", n, 7);

    // ch3: div=1
    cfg_write(3, 1);
    step();
    ch_en = 4'b1111;
    step();
    check("t4_tick_a", tick[3], 1);
    check("t4_dout_a", div_out[3], 1);
    step();
    check("t4_tick_b", tick[3], 1);
    check("t4_dout_b", div_out[3], 0);
    step();
    check("t4_tick_c", tick[3], 1);
    check("t4_dout_c", div_out[3], 1);
    ch_en = 4'b0111;
    step();
    check("t4_dis_tick", tick[3], 0);
    check("t4_dis_dout", div_out[3], 0);

    // sync restart with 2,3,4,6
    for (int c = 0; c < 4; c++) cfg_write(c, divs[c]);
    ch_en        = 4'b1111;
    sync_restart = 1'b1;
    step();
    sync_restart = 1'b0;
    check("t5_rs_tick", tick, 0);
    check("t5_rs_dout", div_out, 0);
    for (int k = 1; k <= 12; k++) begin
      step();
      for (int c = 0; c < 4; c++) begin
        exp_tick[c] = ((k % divs[c]) == 0);
        exp_dout[c] = ((k / divs[c]) % 2) == 1;
      end
      check($sformatf("t5_tick_k%0d", k), tick, exp_tick);
      check($sformatf("t5_dout_k%0d", k), div_out, exp_dout);
    end

    // async reset mid-count with a pending ratio
    ch_en = 4'b0001;
    cfg_write(0, 5);
    arst_n = 1'b0;
    #1;
    check("t6_async_ack", cfg_ack, 0);
    check("t6_async_tick", tick, 0);
    check("t6_async_dout", div_out, 0);
    step();
    arst_n = 1'b1;
    find_tick(0, 30, n);
    check("t6_first_def", n, 8);
    find_tick(0, 30, n);
    check("t6_second_def", n, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prog_tick_divider.md
Name: prog_tick_divider

Overview:
Parametrised successor to the fixed free-running bit-tap clock divider. It provides NUM_CH independent channels, each with a runtime-programmable divide ratio, per-channel enable, a single-cycle tick (clock-enable) output and a 50%-duty divided-clock output. Divide ratios are reprogrammed glitch-free through a one-write config port, and a global synchronous restart phase-aligns all channels. It feeds the display counter, digit multiplexer and shift-register stages that currently consume raw counter taps.

Parameters:
NUM_CH, 4, number of divider channels (1..16)
CNT_W, 32, width of divide ratio and per-channel counter
DEF_DIV, 134217728, divide ratio loaded into every channel at reset (must be >=1 and <2^CNT_W)
CH_W, 4, width of channel select (>= clog2(NUM_CH), minimum 1)

Ports:
clk  in  1  system clock, all logic rising-edge
arst_n  in  1  asynchronous active-low reset
ch_en  in  NUM_CH  per-channel run enable, bit i = channel i
sync_restart  in  1  synchronous restart of all channels, single-cycle pulse
cfg_wr  in  1  config write strobe, single cycle
cfg_ch  in  CH_W  target channel of cfg_wr
cfg_div  in  CNT_W  new divide ratio
cfg_ack  out  1  one-cycle pulse, write accepted
cfg_err  out  1  one-cycle pulse, write rejected
tick  out  NUM_CH  per-channel single-cycle enable pulse, period = div cycles
div_out  out  NUM_CH  per-channel divided clock, period = 2*div cycles, 50% duty

Behaviour:
- Reset (arst_n=0, async): div[i]=DEF_DIV, pend_vld[i]=0, cnt[i]=0, tick=0, div_out=0, cfg_ack=0, cfg_err=0.
- Per channel, state: active div, pending value plus pend_vld, cnt.
- Enabled channel (ch_en[i]=1): cnt increments each cycle. When cnt==div-1 (terminal), the next edge sets cnt to 0, registers tick[i]=1 for exactly one cycle and toggles div_out[i]. tick is otherwise 0.
- Terminal edge with pend_vld=1: div takes the pending value and pend_vld is cleared. The new ratio governs the very next count period. No partial or short period is ever produced.
- div=1: terminal every cycle. tick held high continuously; div_out toggles every cycle (clk/2).
- Disabled channel (ch_en[i]=0): cnt forced to 0, tick 0, div_out forced 0. Pending, if valid, is applied immediately at that edge. On re-enable, the first tick is registered div cycles after the first enabled edge.
- sync_restart=1: for all channels at that edge, cnt=0, tick=0, div_out=0, and any valid pending value is applied. sync_restart overrides terminal detection in the same cycle.
- Config path: cfg_wr is valid if cfg_ch<NUM_CH and cfg_div!=0.
  - Valid write: loads pending[cfg_ch], sets pend_vld, and pulses cfg_ack on the next cycle.
  - Invalid write: no state change; pulses cfg_err on the next cycle.
  - cfg_ack and cfg_err are never both high.
  - Back-to-back writes are accepted every cycle. The last write before a terminal wins.
- Simultaneous cfg_wr and terminal (or sync_restart, or disabled channel) on the same channel: the terminal applies the pending value held before the edge, and the new write lands in pending for the following period. Pending-value comparisons always use the pre-edge value.
- Counter arithmetic is unsigned, CNT_W wide, and never exceeds div-1.
- Reset asserted mid-period: all outputs drop to reset values asynchronously. After release, counting starts from 0 with DEF_DIV.

Test Plan:
- Reset then ch_en=4'b0001, DEF_DIV overridden via cfg to 5 on ch0 -> cfg_ack 1 cycle after write; after the next terminal, tick[0] pulses every 5 cycles and div_out[0] has a 10-cycle period, high 5, low 5.
- ch1 div=3 running; write cfg_div=7 mid-period -> the current 3-cycle period completes unaltered, then 7-cycle periods follow; no tick gap shorter than 3 or longer than 7.
- cfg_div=0 on ch2, and cfg_ch=9 with NUM_CH=4 -> cfg_err pulses each time, cfg_ack stays 0, ch2 ratio unchanged.
- div=1 on ch3 -> tick[3] constantly 1 while enabled; div_out[3] toggles each cycle. Drop ch_en[3] -> tick 0 and div_out 0 on the next edge.
- Channels 0..3 with divs 2,3,4,6; pulse sync_restart -> all div_out=0 and cnt=0 that edge; all channels produce their first tick together 12 cycles later.
- arst_n low for 1 cycle mid-count with div=5 pending -> outputs 0 immediately, pending discarded, next period uses DEF_DIV (tested with DEF_DIV=8): first tick 8 cycles after release.
